// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
//   Multi-cycle control sequencer for the RV32-style datapath. Walks each
//   instruction through FETCH/DECODE/EXEC/MEM/WB. The single memory port is
//   shared between instruction fetch and load/store. Every memory access
//   waits on mem_ready and is bounded by a timeout that parks the machine in
//   ERR. A halt opcode parks the machine in HALT and pulses createdump once.
//
// Parameters
//   MEM_TIMEOUT  consecutive mem_ready-low cycles in FETCH/MEM before ERR (1..255)
//   OPC_HALT     opcode that halts the CPU and requests a memory dump
//
// Ports
//   clk, rst (async, active-low)
//   opcode, alu_zero, mem_ready                    : inputs from the datapath/memory
//   mem_en, mem_wr, mem_sel_data                   : memory port control
//   ir_we, pc_we, pc_src                           : fetch / PC control
//   rf_we, wb_sel, alu_src_imm                     : register file / ALU control
//   state, halted, createdump, mem_err             : status
//   instret, cycles                                : performance counters
//
// Build option
//   CTRL_PERF_EN  when defined, instret/cycles count; otherwise both read 0.
module multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 8,
  parameter logic [6:0]  OPC_HALT    = 7'h73
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  opcode,
  input  logic        alu_zero,
  input  logic        mem_ready,
  output logic        mem_en,
  output logic        mem_wr,
  output logic        mem_sel_data,
  output logic        ir_we,
  output logic        pc_we,
  output logic        pc_src,
  output logic        rf_we,
  output logic        wb_sel,
  output logic        alu_src_imm,
  output logic [2:0]  state,
  output logic        halted,
  output logic        createdump,
  output logic        mem_err,
  output logic [31:0] instret,
  output logic [31:0] cycles
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    C_NOP, C_LOAD, C_STORE, C_ITYPE, C_RTYPE, C_BRANCH, C_HALT
  } opc_t;

  // Last low cycle that is still tolerated; the next low cycle times out.
  localparam logic [7:0] WAIT_LIMIT = 8'(MEM_TIMEOUT - 1);

  state_t     state_reg, state_next;
  opc_t       class_reg, dec_class;
  logic [7:0] wait_cnt_reg, wait_cnt_next;
  logic       createdump_reg;
  logic       mem_err_reg;
  logic       in_halt;

  // Halt is tested first so it still wins if OPC_HALT aliases another class.
  always_comb begin
    dec_class = C_NOP;
    if (opcode == OPC_HALT) dec_class = C_HALT;
    else begin
      case (opcode)
        7'h03:   dec_class = C_LOAD;
        7'h23:   dec_class = C_STORE;
        7'h13:   dec_class = C_ITYPE;
        7'h33:   dec_class = C_RTYPE;
        7'h63:   dec_class = C_BRANCH;
        default: dec_class = C_NOP;
      endcase
    end
  end

  // Next state and wait counter. The counter only survives while the FSM
  // stays in a memory-wait state; any transition clears it.
  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = 8'd0;
    case (state_reg)
      S_FETCH, S_MEM: begin
        if (mem_ready) begin
          if (state_reg == S_FETCH)       state_next = S_DECODE;
          else if (class_reg == C_STORE)  state_next = S_FETCH;
          else                            state_next = S_WB;
        end else if (wait_cnt_reg == WAIT_LIMIT) begin
          state_next = S_ERR;
        end else begin
          wait_cnt_next = wait_cnt_reg + 8'd1;
        end
      end
      S_DECODE: begin
        case (dec_class)
          C_HALT:  state_next = S_HALT;
          C_NOP:   state_next = S_FETCH;
          default: state_next = S_EXEC;
        endcase
      end
      S_EXEC: begin
        case (class_reg)
          C_RTYPE, C_ITYPE: state_next = S_WB;
          C_LOAD, C_STORE:  state_next = S_MEM;
          default:          state_next = S_FETCH;
        endcase
      end
      S_WB:    state_next = S_FETCH;
      S_HALT:  state_next = S_HALT;
      S_ERR:   state_next = S_ERR;
      default: state_next = S_ERR;
    endcase
  end

  // Opcode class is latched in DECODE so WB still knows whether it is
  // finishing a load, without looking at opcode outside DECODE/EXEC/MEM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= S_FETCH;
      class_reg      <= C_NOP;
      wait_cnt_reg   <= 8'd0;
      createdump_reg <= 1'b0;
      mem_err_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      wait_cnt_reg   <= wait_cnt_next;
      if (state_reg == S_DECODE) class_reg <= dec_class;
      // High only during the first HALT cycle.
      createdump_reg <= (state_reg == S_DECODE) && (state_next == S_HALT);
      if (state_next == S_ERR) mem_err_reg <= 1'b1;
    end
  end

  assign in_halt = (state_reg == S_HALT) || (state_reg == S_ERR);

  // Moore decode of the control outputs. The whole set is gated by rst so
  // that asserting reset kills every enable immediately, not on the next edge.
  always_comb begin
    mem_en       = 1'b0;
    mem_wr       = 1'b0;
    mem_sel_data = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_src       = 1'b0;
    rf_we        = 1'b0;
    wb_sel       = 1'b0;
    alu_src_imm  = 1'b0;
    if (rst) begin
      case (state_reg)
        S_FETCH: begin
          mem_en = 1'b1;
          ir_we  = mem_ready;
          pc_we  = mem_ready;
        end
        S_EXEC: begin
          alu_src_imm = (class_reg == C_ITYPE) || (class_reg == C_LOAD) ||
                        (class_reg == C_STORE);
          if (class_reg == C_BRANCH) begin
            pc_we  = alu_zero;
            pc_src = alu_zero;
          end
        end
        S_MEM: begin
          mem_en       = 1'b1;
          mem_sel_data = 1'b1;
          alu_src_imm  = 1'b1;
          mem_wr       = (class_reg == C_STORE);
        end
        S_WB: begin
          rf_we  = 1'b1;
          wb_sel = (class_reg == C_LOAD);
        end
        default: ;
      endcase
    end
  end

  assign state      = state_reg;
  assign halted     = rst && in_halt;
  assign createdump = createdump_reg;
  assign mem_err    = mem_err_reg;

`ifdef CTRL_PERF_EN
  logic [31:0] cycles_reg;
  logic [31:0] instret_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycles_reg  <= 32'd0;
      instret_reg <= 32'd0;
    end else begin
      if (!in_halt) cycles_reg <= cycles_reg + 32'd1;
      // Retirement = returning to FETCH from any instruction stage.
      if ((state_next == S_FETCH) &&
          ((state_reg == S_DECODE) || (state_reg == S_EXEC) ||
           (state_reg == S_MEM)    || (state_reg == S_WB)))
        instret_reg <= instret_reg + 32'd1;
    end
  end

  assign cycles  = cycles_reg;
  assign instret = instret_reg;
`else
  assign cycles  = 32'h0;
  assign instret = 32'h0;
`endif

endmodule
